// File: rtl/a0_control_sequencer.sv
// rtl/a0_control_sequencer.sv - opcode-driven control FSM for the A0 register stage mux selects and write strobe
module a0_control_sequencer #(
    parameter int COUNT_W  = 8,
    parameter int MAX_ITER = 255
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [2:0]         instr_op,
    input  logic               sub_borrow,
    output logic               CTRL1,
    output logic               CTRL5,
    output logic               CTRL6,
    output logic               a0_we,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               ovf,
    output logic [COUNT_W-1:0] quotient
);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LDI    = 3'd1;
    localparam logic [2:0] OP_MOVA1  = 3'd2;
    localparam logic [2:0] OP_SUB    = 3'd3;
    localparam logic [2:0] OP_DIVSUB = 3'd4;

    localparam logic [COUNT_W-1:0] MAX_Q = COUNT_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] op_q;
    logic       err_q;
    logic       ovf_q;
    logic       accept;
    logic       reserved_op;
    logic       is_divsub;
    logic       at_limit;

    assign accept      = (state == S_IDLE) && instr_valid;
    assign reserved_op = (instr_op > OP_DIVSUB);
    assign is_divsub   = (op_q == OP_DIVSUB);
    assign at_limit    = (quotient == MAX_Q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every output below depends only on registered state, op_q and flags.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        CTRL1       = 1'b0;
        CTRL5       = 1'b0;
        CTRL6       = 1'b0;
        a0_we       = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        err         = 1'b0;
        ovf         = 1'b0;
        unique case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    if (instr_op == OP_NOP || reserved_op) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                CTRL1      = (op_q == OP_LDI);
                CTRL5      = (op_q == OP_MOVA1);
                CTRL6      = (op_q == OP_SUB) || is_divsub;
                state_next = is_divsub ? S_CHECK : S_WRITE;
            end
            S_WRITE: begin
                CTRL1      = (op_q == OP_LDI);
                CTRL5      = (op_q == OP_MOVA1);
                CTRL6      = (op_q == OP_SUB) || is_divsub;
                a0_we      = 1'b1;
                state_next = is_divsub ? S_CHECK : S_DONE;
            end
            S_CHECK: begin
                CTRL6 = 1'b1;
                if (sub_borrow || at_limit) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_WRITE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                err        = err_q;
                ovf        = ovf_q;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The limit test in CHECK precedes the increment in WRITE, so quotient never wraps.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q     <= 3'd0;
            quotient <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            op_q     <= instr_op;
            quotient <= '0;
            err_q    <= reserved_op;
            ovf_q    <= 1'b0;
        end else if (state == S_WRITE && is_divsub) begin
            quotient <= quotient + COUNT_W'(1);
        end else if (state == S_CHECK && !sub_borrow && at_limit) begin
            ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_a0_control_sequencer.sv
// tb/tb_a0_control_sequencer.sv - directed self-checking bench for a0_control_sequencer with an A0/A1 datapath model
module tb_a0_control_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] instr_op = 3'd0;
    logic       sub_borrow;
    logic       CTRL1, CTRL5, CTRL6, a0_we, busy, done, err, ovf;
    logic [7:0] quotient;

    logic [15:0] a0_reg = 16'h0000;
    logic [15:0] a1_val = 16'h0000;
    logic [15:0] reg_in = 16'h0000;
    logic [15:0] mux1, mux5, mux6;

    int checks = 0;
    int errors = 0;

    int          done_cyc;
    int          we_cnt;
    logic [15:0] c1_bits, c5_bits, c6_bits, we_bits;
    logic        err_d, ovf_d, ready_after;
    logic [7:0]  q_d, q_after;

    a0_control_sequencer #(.COUNT_W(8), .MAX_ITER(255)) dut (
        .CLK(CLK), .RST_N(RST_N), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .sub_borrow(sub_borrow), .CTRL1(CTRL1), .CTRL5(CTRL5),
        .CTRL6(CTRL6), .a0_we(a0_we), .busy(busy), .done(done), .err(err), .ovf(ovf),
        .quotient(quotient)
    );

    always #5 CLK = ~CLK;

    assign mux1       = CTRL1 ? reg_in : a0_reg;
    assign mux5       = CTRL5 ? a1_val : mux1;
    assign mux6       = CTRL6 ? (a0_reg - a1_val) : mux5;
    assign sub_borrow = (a0_reg < a1_val);

    always @(posedge CLK) begin
        if (a0_we) a0_reg <= mux6;
    end

    task automatic run_op(input logic [2:0] op, input int max_cyc);
        int n;
        logic seen;
        @(negedge CLK);
        instr_op    = op;
        instr_valid = 1'b1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready op=%0d: got %b expected 1", op, instr_ready);
        end
        @(posedge CLK);
        #1;
        instr_valid = 1'b0;
        instr_op    = 3'd0;
        n = 0; seen = 1'b0; done_cyc = 0; we_cnt = 0;
        c1_bits = '0; c5_bits = '0; c6_bits = '0; we_bits = '0;
        err_d = 1'b0; ovf_d = 1'b0; q_d = '0;
        while (!seen && n < max_cyc) begin
            @(negedge CLK);
            n++;
            if (n < 16) begin
                c1_bits[n] = CTRL1; c5_bits[n] = CTRL5;
                c6_bits[n] = CTRL6; we_bits[n] = a0_we;
            end
            if (a0_we === 1'b1) we_cnt++;
            if (done === 1'b1) begin
                seen = 1'b1; done_cyc = n; err_d = err; ovf_d = ovf; q_d = quotient;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout op=%0d: no done within %0d cycles", op, max_cyc);
        end
        @(negedge CLK);
        ready_after = instr_ready;
        q_after     = quotient;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({instr_ready, busy, done, err, ovf, CTRL1, CTRL5, CTRL6, a0_we} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 100000000",
                     {instr_ready, busy, done, err, ovf, CTRL1, CTRL5, CTRL6, a0_we});
        end
        checks++;
        if (quotient !== 8'd0) begin
            errors++;
            $display("FAIL reset_quotient: got %0d expected 0", quotient);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_ldi_mova1();
        reg_in = 16'h1234;
        run_op(3'd1, 20);
        checks++;
        if (c1_bits !== 16'h0006 || c5_bits !== 16'h0 || c6_bits !== 16'h0) begin
            errors++;
            $display("FAIL ldi_selects: got c1=%h c5=%h c6=%h expected 0006 0000 0000", c1_bits, c5_bits, c6_bits);
        end
        checks++;
        if (we_bits !== 16'h0004) begin
            errors++;
            $display("FAIL ldi_we: got %h expected 0004", we_bits);
        end
        checks++;
        if (done_cyc !== 3 || ready_after !== 1'b1 || err_d !== 1'b0) begin
            errors++;
            $display("FAIL ldi_timing: got done=%0d ready=%b err=%b expected 3 1 0", done_cyc, ready_after, err_d);
        end
        checks++;
        if (a0_reg !== 16'h1234) begin
            errors++;
            $display("FAIL ldi_a0: got %h expected 1234", a0_reg);
        end
        a1_val = 16'h00AA;
        run_op(3'd2, 20);
        checks++;
        if (c5_bits !== 16'h0006 || c1_bits !== 16'h0 || c6_bits !== 16'h0 || we_bits !== 16'h0004) begin
            errors++;
            $display("FAIL mova1_selects: got c1=%h c5=%h c6=%h we=%h expected 0000 0006 0000 0004",
                     c1_bits, c5_bits, c6_bits, we_bits);
        end
        checks++;
        if (done_cyc !== 3 || ready_after !== 1'b1 || a0_reg !== 16'h00AA) begin
            errors++;
            $display("FAIL mova1_result: got done=%0d ready=%b a0=%h expected 3 1 00aa", done_cyc, ready_after, a0_reg);
        end
    endtask

    task automatic test_sub();
        reg_in = 16'h0010;
        run_op(3'd1, 20);
        a1_val = 16'h0003;
        run_op(3'd3, 20);
        checks++;
        if (c6_bits !== 16'h0006 || c1_bits !== 16'h0 || c5_bits !== 16'h0 || we_cnt !== 1) begin
            errors++;
            $display("FAIL sub_selects: got c6=%h c1=%h c5=%h writes=%0d expected 0006 0000 0000 1",
                     c6_bits, c1_bits, c5_bits, we_cnt);
        end
        checks++;
        if (a0_reg !== 16'h000D || done_cyc !== 3) begin
            errors++;
            $display("FAIL sub_result: got a0=%h done=%0d expected 000d 3", a0_reg, done_cyc);
        end
    endtask

    task automatic test_divsub();
        reg_in = 16'd17;
        run_op(3'd1, 20);
        a1_val = 16'd5;
        run_op(3'd4, 40);
        checks++;
        if (we_cnt !== 3 || a0_reg !== 16'd2 || q_d !== 8'd3) begin
            errors++;
            $display("FAIL divsub_result: got writes=%0d a0=%0d q=%0d expected 3 2 3", we_cnt, a0_reg, q_d);
        end
        checks++;
        if (done_cyc !== 9 || ovf_d !== 1'b0 || err_d !== 1'b0) begin
            errors++;
            $display("FAIL divsub_done: got done=%0d ovf=%b err=%b expected 9 0 0", done_cyc, ovf_d, err_d);
        end
        checks++;
        if (c6_bits !== 16'h01FE || we_bits !== 16'h00A8) begin
            errors++;
            $display("FAIL divsub_pattern: got c6=%h we=%h expected 01fe 00a8", c6_bits, we_bits);
        end
        checks++;
        if (q_after !== 8'd3) begin
            errors++;
            $display("FAIL divsub_hold: got q=%0d expected 3", q_after);
        end
    endtask

    task automatic test_reset_mid_write();
        reg_in = 16'h5555;
        @(negedge CLK);
        instr_op = 3'd1; instr_valid = 1'b1;
        @(posedge CLK);
        #1;
        instr_valid = 1'b0; instr_op = 3'd0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (a0_we !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_write: got a0_we=%b expected 1", a0_we);
        end
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (a0_we !== 1'b0 || instr_ready !== 1'b1 || CTRL1 !== 1'b0 || quotient !== 8'd0) begin
            errors++;
            $display("FAIL midreset_async: got we=%b ready=%b ctrl1=%b q=%0d expected 0 1 0 0",
                     a0_we, instr_ready, CTRL1, quotient);
        end
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || a0_we !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet cyc %0d: got done=%b busy=%b we=%b expected 0 0 0", i, done, busy, a0_we);
            end
        end
        checks++;
        if (a0_reg === 16'h5555) begin
            errors++;
            $display("FAIL midreset_a0: got %h expected not 5555", a0_reg);
        end
    endtask

    task automatic test_divsub_limits();
        reg_in = 16'd4;
        run_op(3'd1, 20);
        a1_val = 16'd0;
        run_op(3'd4, 600);
        checks++;
        if (q_d !== 8'd255 || ovf_d !== 1'b1 || done_cyc !== 513 || we_cnt !== 255) begin
            errors++;
            $display("FAIL divsub_ovf: got q=%0d ovf=%b done=%0d writes=%0d expected 255 1 513 255",
                     q_d, ovf_d, done_cyc, we_cnt);
        end
        reg_in = 16'd3;
        run_op(3'd1, 20);
        a1_val = 16'd5;
        run_op(3'd4, 40);
        checks++;
        if (we_cnt !== 0 || q_d !== 8'd0 || done_cyc !== 3 || ovf_d !== 1'b0 || a0_reg !== 16'd3) begin
            errors++;
            $display("FAIL divsub_zero: got writes=%0d q=%0d done=%0d ovf=%b a0=%0d expected 0 0 3 0 3",
                     we_cnt, q_d, done_cyc, ovf_d, a0_reg);
        end
    endtask

    task automatic test_reserved_nop();
        run_op(3'd6, 20);
        checks++;
        if (done_cyc !== 1 || err_d !== 1'b1 || we_cnt !== 0 || ready_after !== 1'b1) begin
            errors++;
            $display("FAIL reserved: got done=%0d err=%b writes=%0d ready=%b expected 1 1 0 1",
                     done_cyc, err_d, we_cnt, ready_after);
        end
        run_op(3'd0, 20);
        checks++;
        if (done_cyc !== 1 || err_d !== 1'b0 || we_cnt !== 0) begin
            errors++;
            $display("FAIL nop: got done=%0d err=%b writes=%0d expected 1 0 0", done_cyc, err_d, we_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rdy_bits, c6b, doneb;
        int writes;
        rdy_bits = '0; c6b = '0; doneb = '0; writes = 0;
        reg_in = 16'h0010;
        a1_val = 16'h0003;
        @(negedge CLK);
        instr_op = 3'd1; instr_valid = 1'b1;
        @(posedge CLK);
        #1;
        instr_op = 3'd3;
        for (int n = 1; n < 12; n++) begin
            @(negedge CLK);
            rdy_bits[n] = instr_ready; c6b[n] = CTRL6; doneb[n] = done;
            if (a0_we === 1'b1) writes++;
            if (n == 4) begin
                @(posedge CLK);
                #1;
                instr_valid = 1'b0; instr_op = 3'd0;
            end
        end
        checks++;
        if (rdy_bits[4:1] !== 4'b1000 || doneb[7:1] !== 7'b1000100) begin
            errors++;
            $display("FAIL b2b_handshake: got ready=%b done=%b expected 1000 1000100", rdy_bits[4:1], doneb[7:1]);
        end
        checks++;
        if (c6b[7:5] !== 3'b011 || writes !== 2 || a0_reg !== 16'h000D) begin
            errors++;
            $display("FAIL b2b_sub: got c6=%b writes=%0d a0=%h expected 011 2 000d", c6b[7:5], writes, a0_reg);
        end
    endtask

    initial begin
        test_reset();
        test_ldi_mova1();
        test_sub();
        test_divsub();
        test_reset_mid_write();
        test_divsub_limits();
        test_reserved_nop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
